// File: rtl/eth_tx_framer.sv
// eth_tx_framer: builds Ethernet frames (no FCS) from a header request plus a byte
// AXI-Stream payload. Ports: hdr_* request, in_* payload, out_* frame, frame_count.
module eth_tx_framer #(
  parameter logic [47:0] SRC_MAC = 48'hDEADBEEF1234,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hdr_valid,
  output logic             hdr_ready,
  input  logic [47:0]      hdr_dst_mac,
  input  logic [15:0]      hdr_ethertype,
  input  logic             in_tvalid,
  output logic             in_tready,
  input  logic [7:0]       in_tdata,
  input  logic             in_tlast,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic [7:0]       out_tdata,
  output logic             out_tlast,
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PAY, S_PAD, S_DONE
  } state_t;

  localparam logic [11:0] MIN_W = 12'(MIN_FRAME_BYTES);

  state_t state_q, state_d;
  logic [47:0] dst_q, dst_d;
  logic [15:0] et_q, et_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d;
  logic last_q, last_d;
  logic [CNT_W-1:0] fc_q, fc_d;

  logic adv, tl_hs, hdr_acc, in_acc;
  logic [10:0] cnt_inc;
  logic [11:0] total;
  logic [111:0] hdr_vec, hdr_sh;
  logic [7:0] hdr_byte;

  assign adv = !valid_q || out_tready;
  assign tl_hs = valid_q && out_tready && last_q;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 11'd1;
  // length of the frame once the byte being loaded now is counted
  assign total = {1'b0, cnt_q} + 12'd1;

  // header byte selected by the byte counter, MSB-first
  assign hdr_vec = {dst_q, SRC_MAC, et_q};
  assign hdr_sh = hdr_vec << {cnt_q[3:0], 3'b000};
  assign hdr_byte = hdr_sh[111:104];

  // DONE accepts the next header in the cycle its tlast byte leaves
  assign hdr_ready = !rst &&
    ((state_q == S_IDLE && adv) ||
     (state_q == S_DONE && tl_hs));
  assign in_tready = !rst && state_q == S_PAY && adv;
  assign hdr_acc = hdr_valid && hdr_ready;
  assign in_acc = in_tvalid && in_tready;

  assign out_tvalid = valid_q;
  assign out_tdata = data_q;
  assign out_tlast = last_q;
  assign frame_count = fc_q;

  always_comb begin
    state_d = state_q;
    dst_d = dst_q;
    et_d = et_q;
    cnt_d = cnt_q;
    data_d = data_q;
    valid_d = valid_q;
    last_d = last_q;
    fc_d = fc_q;
    if (adv) begin
      valid_d = 1'b0;
      last_d = 1'b0;
    end
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE && tl_hs) begin
          fc_d = fc_q + CNT_W'(1);
          cnt_d = '0;
          state_d = S_IDLE;
        end
        if (hdr_acc) begin
          dst_d = hdr_dst_mac;
          et_d = hdr_ethertype;
          data_d = hdr_dst_mac[47:40];
          valid_d = 1'b1;
          cnt_d = 11'd1;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (adv) begin
          data_d = hdr_byte;
          valid_d = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_q == 11'd13) state_d = S_PAY;
        end
      end
      S_PAY: begin
        if (in_acc) begin
          data_d = in_tdata;
          valid_d = 1'b1;
          cnt_d = cnt_inc;
          if (in_tlast) begin
            if (total >= MIN_W) begin
              last_d = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        if (adv) begin
          data_d = 8'h00;
          valid_d = 1'b1;
          cnt_d = cnt_inc;
          if (total >= MIN_W) begin
            last_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dst_q <= '0;
      et_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      fc_q <= '0;
    end else begin
      state_q <= state_d;
      dst_q <= dst_d;
      et_q <= et_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      valid_q <= valid_d;
      last_q <= last_d;
      fc_q <= fc_d;
    end
  end

endmodule
